m3_phasedriver: RTL and testbench

- Consumer end of the m3 speed/power command path. Takes the working flag, the target round length and the power level produced by the speed/step calculation. Drives the six gate signals of a 3-phase bridge using six-step commutation.
- The high side is PWM-modulated by the power level. A dead-time gap is inserted on every commutation. All gates are forced off whenever the drive is not working.
- Sits between the m3 power/speed calculation and the bridge pins.

---
 rtl/m3_pkg.sv | 37 +++
 rtl/m3_pwmCounter.sv | 26 ++
 rtl/m3_phasedriver.sv | 146 ++++++++++++++
 tb/tb_m3_phasedriver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/m3_pkg.sv
// Shared encodings for the m3 phase driver: step codes, FSM states and the
// six-step gate pattern table (bit0 = A, bit1 = B, bit2 = C).
package m3_pkg;

    localparam logic [2:0] STEP_AB = 3'd0;
    localparam logic [2:0] STEP_AC = 3'd1;
    localparam logic [2:0] STEP_BC = 3'd2;
    localparam logic [2:0] STEP_BA = 3'd3;
    localparam logic [2:0] STEP_CA = 3'd4;
    localparam logic [2:0] STEP_CB = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef struct packed {
        logic [2:0] high;
        logic [2:0] low;
    } gate_pat_t;

    // Floating phase has both gates low; out-of-range codes drive nothing.
    function automatic gate_pat_t gate_pattern(input logic [2:0] step);
        gate_pat_t pat;
        pat = '0;
        case (step)
            STEP_AB: pat = '{high: 3'b001, low: 3'b010};
            STEP_AC: pat = '{high: 3'b001, low: 3'b100};
            STEP_BC: pat = '{high: 3'b010, low: 3'b100};
            STEP_BA: pat = '{high: 3'b010, low: 3'b001};
            STEP_CA: pat = '{high: 3'b100, low: 3'b001};
            STEP_CB: pat = '{high: 3'b100, low: 3'b010};
            default: pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/m3_pwmCounter.sv
// Free-running PWM counter for the high-side gate; cleared while the drive is idle.
module m3_pwmCounter #(
    parameter int unsigned PWR_W = 8
) (
    input  logic             clkI,
    input  logic             nRstI,
    input  logic             i_run,
    input  logic [PWR_W-1:0] i_power,
    output logic             o_high_en
);

    logic [PWR_W-1:0] r_cnt;

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_cnt <= '0;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PWR_W'(1);
        end
    end

    assign o_high_en = (r_cnt < i_power);

endmodule

// File: rtl/m3_phasedriver.sv
// Six-step commutation driver for a 3-phase bridge with PWM high side and dead time.
// Step timing uses a Bresenham accumulator so the average step is exactly roundLen / 6.
module m3_phasedriver
    import m3_pkg::*;
#(
    parameter int unsigned PWR_W     = 8,
    parameter int unsigned DEAD_T    = 4,
    parameter int unsigned MIN_ROUND = 600
) (
    input  logic             clkI,
    input  logic             nRstI,
    input  logic             workingI,
    input  logic             invRotateI,
    input  logic [31:0]      dstRoundLenI,
    input  logic [PWR_W-1:0] powerI,
    output logic [2:0]       phaseHighO,
    output logic [2:0]       phaseLowO,
    output logic [2:0]       stepO,
    output logic             roundDoneO
);

    localparam int unsigned DEAD_W = (DEAD_T > 1) ? $clog2(DEAD_T) : 1;

    logic [1:0]        r_state, w_state_d;
    logic [2:0]        r_step, w_step_d;
    logic [32:0]       r_acc, w_acc_d;
    logic [DEAD_W-1:0] r_dead_cnt, w_dead_d;
    logic [31:0]       r_round_len, w_len_d;
    logic              r_startup, w_startup_d;
    logic              w_done_d;
    logic [2:0]        r_high, r_low;
    logic              r_round_done;

    logic [31:0] w_round_clamp;
    logic [32:0] w_acc_inc;
    logic        w_hit;
    logic [2:0]  w_step_next;
    logic        w_wrap;
    logic        w_pwm_en;
    gate_pat_t   w_pat;
    logic        w_run_d;

    assign w_round_clamp = (dstRoundLenI < MIN_ROUND) ? 32'(MIN_ROUND) : dstRoundLenI;
    assign w_acc_inc     = r_acc + 33'd6;
    assign w_hit         = (w_acc_inc >= {1'b0, r_round_len});
    assign w_step_next   = invRotateI ? ((r_step == STEP_AB) ? STEP_CB : r_step - 3'd1)
                                      : ((r_step == STEP_CB) ? STEP_AB : r_step + 3'd1);
    assign w_wrap        = invRotateI ? (r_step == STEP_AB) : (r_step == STEP_CB);

    always_comb begin
        w_state_d   = r_state;
        w_step_d    = r_step;
        w_acc_d     = r_acc;
        w_dead_d    = r_dead_cnt;
        w_len_d     = r_round_len;
        w_startup_d = r_startup;
        w_done_d    = 1'b0;
        if (!workingI) begin
            w_state_d = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_d   = ST_DEAD;
                    w_step_d    = STEP_AB;
                    w_acc_d     = '0;
                    w_dead_d    = '0;
                    w_startup_d = 1'b1;
                end
                ST_DEAD: begin
                    // Start-up dead time does not count toward step time.
                    if (!r_startup) begin
                        w_acc_d = w_acc_inc;
                    end
                    if (r_dead_cnt == DEAD_W'(DEAD_T - 1)) begin
                        w_state_d   = ST_RUN;
                        w_startup_d = 1'b0;
                        if (r_startup) begin
                            w_len_d = w_round_clamp;
                        end
                    end else begin
                        w_dead_d = r_dead_cnt + DEAD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_hit) begin
                        w_acc_d   = w_acc_inc - {1'b0, r_round_len};
                        w_step_d  = w_step_next;
                        w_state_d = ST_DEAD;
                        w_dead_d  = '0;
                        if (w_wrap) begin
                            w_len_d  = w_round_clamp;
                            w_done_d = 1'b1;
                        end
                    end else begin
                        w_acc_d = w_acc_inc;
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    m3_pwmCounter #(
        .PWR_W(PWR_W)
    ) u_pwm (
        .clkI      (clkI),
        .nRstI     (nRstI),
        .i_run     (r_state != ST_IDLE),
        .i_power   (powerI),
        .o_high_en (w_pwm_en)
    );

    // Gates are derived from the next state so they switch in step with it.
    assign w_pat   = gate_pattern(w_step_d);
    assign w_run_d = (w_state_d == ST_RUN);

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_state      <= ST_IDLE;
            r_step       <= STEP_AB;
            r_acc        <= '0;
            r_dead_cnt   <= '0;
            r_round_len  <= 32'(MIN_ROUND);
            r_startup    <= 1'b0;
            r_high       <= '0;
            r_low        <= '0;
            r_round_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_step       <= w_step_d;
            r_acc        <= w_acc_d;
            r_dead_cnt   <= w_dead_d;
            r_round_len  <= w_len_d;
            r_startup    <= w_startup_d;
            r_high       <= (w_run_d && w_pwm_en) ? w_pat.high : 3'b000;
            r_low        <= w_run_d ? w_pat.low : 3'b000;
            r_round_done <= w_done_d;
        end
    end

    assign phaseHighO = r_high;
    assign phaseLowO  = r_low;
    assign stepO      = r_step;
    assign roundDoneO = r_round_done;

endmodule

// File: tb/tb_m3_phasedriver.sv
// Scoreboard bench for m3_phasedriver: step events are queued by the stimulus and
// checked by a monitor; gate and duty checks run inline.
module tb_m3_phasedriver;

    logic        clkI = 1'b0;
    logic        nRstI;
    logic        workingI;
    logic        invRotateI;
    logic [31:0] dstRoundLenI;
    logic [7:0]  powerI;
    logic [2:0]  phaseHighO;
    logic [2:0]  phaseLowO;
    logic [2:0]  stepO;
    logic        roundDoneO;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [2:0]  step;
        logic        rd;
        int unsigned gap;   // 0 = spacing not checked
    } evt_t;

    evt_t sb_q[$];

    m3_phasedriver #(
        .PWR_W     (8),
        .DEAD_T    (4),
        .MIN_ROUND (600)
    ) dut (
        .clkI         (clkI),
        .nRstI        (nRstI),
        .workingI     (workingI),
        .invRotateI   (invRotateI),
        .dstRoundLenI (dstRoundLenI),
        .powerI       (powerI),
        .phaseHighO   (phaseHighO),
        .phaseLowO    (phaseLowO),
        .stepO        (stepO),
        .roundDoneO   (roundDoneO)
    );

    always #5 clkI = ~clkI;

    always @(posedge clkI) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clkI);
    endtask

    task automatic push(input logic [2:0] step, input logic rd, input int unsigned gap);
        evt_t e;
        e.step = step;
        e.rd   = rd;
        e.gap  = gap;
        sb_q.push_back(e);
    endtask

    task automatic duty(input string name, input int exp);
        int n;
        n = 0;
        repeat (256) begin
            @(negedge clkI);
            if (|phaseHighO) n++;
        end
        check(name, n, exp);
    endtask

    // Monitor: any step change or round pulse is an output event to score.
    logic [2:0]  prev_step = 3'd0;
    int unsigned last_evt = 0;
    evt_t        cur;

    always @(negedge clkI) begin
        if (nRstI === 1'b1 && (stepO !== prev_step || roundDoneO === 1'b1)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: step=%0d rd=%0d at cycle %0d, none expected",
                         stepO, roundDoneO, cyc);
            end else begin
                cur = sb_q.pop_front();
                check("evt_step", {29'd0, stepO}, {29'd0, cur.step});
                check("evt_round_done", {31'd0, roundDoneO}, {31'd0, cur.rd});
                if (cur.gap != 0) check("evt_spacing", cyc - last_evt, cur.gap);
            end
            last_evt = cyc;
        end
        prev_step = stepO;
    end

    always @(negedge clkI) begin
        if (nRstI === 1'b1) check("no_shoot_through", {29'd0, phaseHighO & phaseLowO}, 32'd0);
    end

    initial begin
        nRstI        = 1'b0;
        workingI     = 1'b0;
        invRotateI   = 1'b0;
        dstRoundLenI = 32'd600;
        powerI       = 8'd128;
        tick(3);
        check("rst_high", {29'd0, phaseHighO}, 32'd0);
        check("rst_low", {29'd0, phaseLowO}, 32'd0);
        check("rst_step", {29'd0, stepO}, 32'd0);
        check("rst_round_done", {31'd0, roundDoneO}, 32'd0);
        nRstI = 1'b1;
        tick(3);
        check("idle_gates", {26'd0, phaseHighO, phaseLowO}, 32'd0);

        // Round 1 at 600: steps every 100 clocks.
        push(3'd1, 1'b0, 0);
        push(3'd2, 1'b0, 100);
        push(3'd3, 1'b0, 100);
        push(3'd4, 1'b0, 100);
        push(3'd5, 1'b0, 100);
        push(3'd0, 1'b1, 100);
        workingI = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("start_dead_gates", {26'd0, phaseHighO, phaseLowO}, 32'd0);
        end
        tick(1);
        check("run_step", {29'd0, stepO}, 32'd0);
        check("run_low", {29'd0, phaseLowO}, 32'd2);
        check("run_high_only_a", {29'd0, phaseHighO & 3'b110}, 32'd0);

        // During step 2: request below minimum, latched clamped to 600 at the wrap.
        tick(246);
        dstRoundLenI = 32'd100;
        for (int s = 1; s <= 5; s++) push(3'(s), 1'b0, 100);
        push(3'd0, 1'b1, 100);

        // During step 3 of round 2: 1200 takes effect only after the wrap.
        tick(700);
        dstRoundLenI = 32'd1200;
        push(3'd1, 1'b0, 200);
        push(3'd2, 1'b0, 200);

        // During step 2 of round 3: reverse; 600 latched on the 0->5 wrap.
        tick(754);
        invRotateI   = 1'b1;
        dstRoundLenI = 32'd600;
        push(3'd1, 1'b0, 200);
        push(3'd0, 1'b0, 200);
        push(3'd5, 1'b1, 200);
        push(3'd4, 1'b0, 100);

        // Drop working mid step 4.
        tick(650);
        workingI = 1'b0;
        tick(1);
        check("stop_gates", {26'd0, phaseHighO, phaseLowO}, 32'd0);
        check("stop_step_held", {29'd0, stepO}, 32'd4);
        tick(5);
        check("stopped_gates", {26'd0, phaseHighO, phaseLowO}, 32'd0);
        check("stopped_step_held", {29'd0, stepO}, 32'd4);

        // Restart with a long round for the duty windows; reverse wrap after 1004 clocks.
        dstRoundLenI = 32'd6000;
        powerI       = 8'd0;
        push(3'd0, 1'b0, 0);
        push(3'd5, 1'b1, 1004);
        workingI = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("restart_dead_gates", {26'd0, phaseHighO, phaseLowO}, 32'd0);
        end
        tick(1);
        check("restart_step", {29'd0, stepO}, 32'd0);
        check("restart_low", {29'd0, phaseLowO}, 32'd2);

        tick(2);
        duty("duty_power0", 0);
        powerI = 8'd255;
        tick(2);
        duty("duty_power255", 255);
        powerI = 8'd128;
        tick(2);
        duty("duty_power128", 128);

        tick(300);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
